// File: rtl/sync_fifo_stream_reader_if.sv
// Bundles the FIFO read port and the valid/ready output stream of the stream reader.
// master = the reader, slave = the FIFO plus downstream consumer.
interface sync_fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd_en;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd_en,
    output m_valid,
    input  m_ready,
    output m_data
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_rd_en,
    input  m_valid,
    output m_ready,
    input  m_data
  );
endinterface

// File: rtl/sync_fifo_stream_reader.sv
// Drains a synchronous FIFO (1-cycle read latency) into a valid/ready stream via a 2-entry buffer.
// Optional transfer counter port xfer_cnt is built when macro READ_CNT_EN is defined.
module sync_fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  sync_fifo_stream_reader_if.master bus
`ifdef READ_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] xfer_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                state_r;
  logic                  inflight_r;
  logic                  m_valid_r;
  logic [DATA_WIDTH-1:0] head_r;
  logic [DATA_WIDTH-1:0] tail_r;

  logic                  pop_s;
  logic                  push_s;
  logic                  rd_en_s;
  logic [1:0]            count_s;
  logic [2:0]            occ_s;

  // Credit check: words held plus the one in flight, minus the word leaving this cycle.
  always_comb begin
    count_s = state_r;
    pop_s   = m_valid_r & bus.m_ready;
    push_s  = inflight_r & ~flush;
    occ_s   = {1'b0, count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
    if (rstn && !flush && !bus.fifo_empty && (occ_s < 3'd2)) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  assign bus.fifo_rd_en = rd_en_s;
  assign bus.m_valid    = m_valid_r;
  assign bus.m_data     = head_r;

  // Buffer occupancy FSM with head/tail capture; flush drops held and in-flight words.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r    <= EMPTY;
      inflight_r <= 1'b0;
      m_valid_r  <= 1'b0;
      head_r     <= '0;
      tail_r     <= '0;
    end else if (flush) begin
      state_r    <= EMPTY;
      inflight_r <= 1'b0;
      m_valid_r  <= 1'b0;
    end else begin
      inflight_r <= rd_en_s;
      case (state_r)
        EMPTY: begin
          if (push_s) begin
            state_r   <= ONE;
            head_r    <= bus.fifo_data;
            m_valid_r <= 1'b1;
          end else begin
            state_r   <= EMPTY;
            m_valid_r <= 1'b0;
          end
        end
        ONE: begin
          if (push_s && pop_s) begin
            head_r    <= bus.fifo_data;
            m_valid_r <= 1'b1;
          end else if (push_s) begin
            state_r   <= TWO;
            tail_r    <= bus.fifo_data;
            m_valid_r <= 1'b1;
          end else if (pop_s) begin
            state_r   <= EMPTY;
            m_valid_r <= 1'b0;
          end else begin
            m_valid_r <= 1'b1;
          end
        end
        TWO: begin
          // push without pop cannot happen here: the credit check withholds the read.
          if (pop_s && push_s) begin
            head_r <= tail_r;
            tail_r <= bus.fifo_data;
          end else if (pop_s) begin
            state_r <= ONE;
            head_r  <= tail_r;
          end else begin
            state_r <= TWO;
          end
          m_valid_r <= 1'b1;
        end
        default: begin
          state_r   <= EMPTY;
          m_valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef READ_CNT_EN
  logic [CNT_WIDTH-1:0] xfer_cnt_r;

  // Counts accepted handshakes; survives flush and wraps naturally.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      xfer_cnt_r <= '0;
    end else if (pop_s && !flush) begin
      xfer_cnt_r <= xfer_cnt_r + CNT_WIDTH'(1'b1);
    end else begin
      xfer_cnt_r <= xfer_cnt_r;
    end
  end

  assign xfer_cnt = xfer_cnt_r;
`endif

endmodule
